c3aibadapt_avmm2_arb: RTL and testbench

Two-requester arbiter and sequencer for the AVMM2 configuration port toward NF HSSI. It shares the single `pld_avmm2_*` interface between the remote AVMM transfer path (port 0) and a local adapter-side configuration master (port 1). The block performs the request/busy handshake, issues one-cycle read/write strobes, and times read-data return with a programmable latency counter. It sits between the AVMM transfer logic and the pass-through AVMM2 config block.

---
 rtl/c3aibadapt_avmm2_arb_if.sv | 51 +++++
 rtl/c3aibadapt_avmm2_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_c3aibadapt_avmm2_arb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c3aibadapt_avmm2_arb_if.sv
// c3aibadapt_avmm2_arb_if
// Signal bundle for the AVMM2 arbiter: two requester command ports
// (rq0 = remote AVMM transfer path, rq1 = local config master) and the
// shared pld_avmm2 port toward NF HSSI.
//   slave  : arbiter view (takes requester commands, drives the HSSI side)
//   master : environment view (requesters plus HSSI responder)
interface c3aibadapt_avmm2_arb_if;
    logic       rq0_read;
    logic       rq0_write;
    logic [8:0] rq0_reg_addr;
    logic [7:0] rq0_writedata;
    logic       rq0_waitrequest;
    logic [7:0] rq0_readdata;
    logic       rq0_readdatavalid;

    logic       rq1_read;
    logic       rq1_write;
    logic [8:0] rq1_reg_addr;
    logic [7:0] rq1_writedata;
    logic       rq1_waitrequest;
    logic [7:0] rq1_readdata;
    logic       rq1_readdatavalid;

    logic       pld_avmm2_busy;
    logic [7:0] pld_avmm2_readdata;
    logic       pld_avmm2_request;
    logic       pld_avmm2_read;
    logic       pld_avmm2_write;
    logic [8:0] pld_avmm2_reg_addr;
    logic [7:0] pld_avmm2_writedata;

    modport slave (
        input  rq0_read, rq0_write, rq0_reg_addr, rq0_writedata,
        output rq0_waitrequest, rq0_readdata, rq0_readdatavalid,
        input  rq1_read, rq1_write, rq1_reg_addr, rq1_writedata,
        output rq1_waitrequest, rq1_readdata, rq1_readdatavalid,
        input  pld_avmm2_busy, pld_avmm2_readdata,
        output pld_avmm2_request, pld_avmm2_read, pld_avmm2_write,
        output pld_avmm2_reg_addr, pld_avmm2_writedata
    );

    modport master (
        output rq0_read, rq0_write, rq0_reg_addr, rq0_writedata,
        input  rq0_waitrequest, rq0_readdata, rq0_readdatavalid,
        output rq1_read, rq1_write, rq1_reg_addr, rq1_writedata,
        input  rq1_waitrequest, rq1_readdata, rq1_readdatavalid,
        output pld_avmm2_busy, pld_avmm2_readdata,
        input  pld_avmm2_request, pld_avmm2_read, pld_avmm2_write,
        input  pld_avmm2_reg_addr, pld_avmm2_writedata
    );
endinterface

// File: rtl/c3aibadapt_avmm2_arb.sv
// c3aibadapt_avmm2_arb
// Two-requester round-robin arbiter/sequencer for the AVMM2 config port.
// Sequence per transfer: IDLE (grant + latch) -> REQ (request, wait !busy)
// -> CMD (one-cycle strobe, acceptance) -> RDWAIT (reads only, latency count).
// All outputs are registered; the next-cycle output values are computed
// from the transition being taken, so CMD-cycle outputs are set when
// leaving REQ.
// Optional feature macro: C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN enables a busy-stall
// timeout (TIMEOUT cycles) with the sticky arb_timeout flag; without it the
// block waits on busy indefinitely and arb_timeout is tied low.
module c3aibadapt_avmm2_arb #(
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                         avmm_clock_dprio_clk,
    input  logic                         avmm_reset_avmm_rst_n,
    c3aibadapt_avmm2_arb_if.slave        avmm2,
    output logic                         arb_timeout
);

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd_latency
        $error("c3aibadapt_avmm2_arb: RD_LATENCY must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("c3aibadapt_avmm2_arb: TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, REQ, CMD, RDWAIT} state_t;

    state_t     state, state_d;

    // grant_q doubles as the round-robin pointer: it keeps the last granted
    // port, and resets to 1 so that port 0 wins the first contention.
    logic       grant_q, grant_d;
    logic       is_wr_q, is_wr_d;
    logic [8:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [3:0] cnt_q, cnt_d;

    logic       pend0, pend1;
    logic       strobe;
    logic       accept;
    logic       ret_valid;
    logic [7:0] ret_data;

    logic       req_q, rd_q, wr_q;
    logic [8:0] paddr_q;
    logic [7:0] pwdata_q;
    logic       wait0_q, wait1_q;
    logic       rdv0_q, rdv1_q;
    logic [7:0] rdata0_q, rdata1_q;

`ifdef C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT);
    logic [7:0] stall_q, stall_d;
    logic       timeout_q, timeout_d;
`endif

    assign pend0 = avmm2.rq0_read | avmm2.rq0_write;
    assign pend1 = avmm2.rq1_read | avmm2.rq1_write;

    assign avmm2.pld_avmm2_request   = req_q;
    assign avmm2.pld_avmm2_read      = rd_q;
    assign avmm2.pld_avmm2_write     = wr_q;
    assign avmm2.pld_avmm2_reg_addr  = paddr_q;
    assign avmm2.pld_avmm2_writedata = pwdata_q;
    assign avmm2.rq0_waitrequest     = wait0_q;
    assign avmm2.rq0_readdatavalid   = rdv0_q;
    assign avmm2.rq0_readdata        = rdata0_q;
    assign avmm2.rq1_waitrequest     = wait1_q;
    assign avmm2.rq1_readdatavalid   = rdv1_q;
    assign avmm2.rq1_readdata        = rdata1_q;

    // FSM state register
    always_ff @(posedge avmm_clock_dprio_clk or negedge avmm_reset_avmm_rst_n) begin
        if (!avmm_reset_avmm_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, grant/latch updates and next-cycle output events
    always_comb begin
        state_d   = state;
        grant_d   = grant_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        strobe    = 1'b0;
        accept    = 1'b0;
        ret_valid = 1'b0;
        ret_data  = avmm2.pld_avmm2_readdata;
`ifdef C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN
        stall_d   = '0;
        timeout_d = timeout_q;
`endif
        unique case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    grant_d = (pend0 && pend1) ? ~grant_q : pend1;
                    // write wins when read and write are both high
                    is_wr_d = grant_d ? avmm2.rq1_write : avmm2.rq0_write;
                    addr_d  = grant_d ? avmm2.rq1_reg_addr : avmm2.rq0_reg_addr;
                    wdata_d = grant_d ? avmm2.rq1_writedata : avmm2.rq0_writedata;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!avmm2.pld_avmm2_busy) begin
                    strobe  = 1'b1;
                    accept  = 1'b1;
                    state_d = CMD;
                end
`ifdef C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN
                else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_d == STALL_LIMIT) begin
                        timeout_d = 1'b1;
                        accept    = 1'b1;
                        ret_valid = !is_wr_q;
                        ret_data  = 8'hFF;
                        state_d   = IDLE;
                    end
                end
`endif
            end
            CMD: begin
                if (is_wr_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = 4'(RD_LATENCY);
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                // cnt_q == 1 is the cycle in which the count reaches 0; the
                // counter then parks at 0 while busy holds the sample off.
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = '0;
                    if (!avmm2.pld_avmm2_busy) begin
                        ret_valid = 1'b1;
                        state_d   = IDLE;
                    end
`ifdef C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN
                    else begin
                        stall_d = stall_q + 8'd1;
                        if (stall_d == STALL_LIMIT) begin
                            timeout_d = 1'b1;
                            ret_valid = 1'b1;
                            ret_data  = 8'hFF;
                            state_d   = IDLE;
                        end
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched transfer, latency counter and registered outputs
    always_ff @(posedge avmm_clock_dprio_clk or negedge avmm_reset_avmm_rst_n) begin
        if (!avmm_reset_avmm_rst_n) begin
            grant_q  <= 1'b1;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            wait0_q  <= 1'b1;
            wait1_q  <= 1'b1;
            rdv0_q   <= 1'b0;
            rdv1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            grant_q  <= grant_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            req_q    <= (state_d != IDLE);
            rd_q     <= strobe && !is_wr_q;
            wr_q     <= strobe && is_wr_q;
            if (strobe) begin
                paddr_q  <= addr_q;
                pwdata_q <= wdata_q;
            end
            wait0_q  <= !(accept && !grant_q);
            wait1_q  <= !(accept && grant_q);
            rdv0_q   <= ret_valid && !grant_q;
            rdv1_q   <= ret_valid && grant_q;
            if (ret_valid && !grant_q) begin
                rdata0_q <= ret_data;
            end
            if (ret_valid && grant_q) begin
                rdata1_q <= ret_data;
            end
        end
    end

`ifdef C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN
    // Consecutive busy-stall counter and sticky timeout flag
    always_ff @(posedge avmm_clock_dprio_clk or negedge avmm_reset_avmm_rst_n) begin
        if (!avmm_reset_avmm_rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb_timeout = timeout_q;
`else
    assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_c3aibadapt_avmm2_arb.sv
// tb_c3aibadapt_avmm2_arb
// Scenario tasks for the AVMM2 arbiter. Expected transfers are queued when a
// requester is driven and popped when the strobe / readdatavalid appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// With C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN defined the timeout scenario also runs.
module tb_c3aibadapt_avmm2_arb;
    localparam int unsigned RD_LAT = 4;
`ifdef C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 255;
`endif

    typedef struct packed {
        logic       port;
        logic       wr;
        logic [8:0] addr;
        logic [7:0] data;
    } xfer_t;

    localparam logic [40:0] RESET_SNAP = {3'b000, 9'h000, 8'h00,
                                          1'b1, 1'b0, 8'h00,
                                          1'b1, 1'b0, 8'h00, 1'b0};

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  arb_timeout;
    xfer_t sb_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    c3aibadapt_avmm2_arb_if bus ();

    c3aibadapt_avmm2_arb #(.RD_LATENCY(RD_LAT), .TIMEOUT(TMO)) dut (
        .avmm_clock_dprio_clk (clk),
        .avmm_reset_avmm_rst_n(rst_n),
        .avmm2                (bus.slave),
        .arb_timeout          (arb_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [40:0] snap();
        return {bus.pld_avmm2_request, bus.pld_avmm2_read, bus.pld_avmm2_write,
                bus.pld_avmm2_reg_addr, bus.pld_avmm2_writedata,
                bus.rq0_waitrequest, bus.rq0_readdatavalid, bus.rq0_readdata,
                bus.rq1_waitrequest, bus.rq1_readdatavalid, bus.rq1_readdata,
                arb_timeout};
    endfunction

    task automatic idle_inputs();
        bus.rq0_read = 1'b0; bus.rq0_write = 1'b0; bus.rq0_reg_addr = '0; bus.rq0_writedata = '0;
        bus.rq1_read = 1'b0; bus.rq1_write = 1'b0; bus.rq1_reg_addr = '0; bus.rq1_writedata = '0;
        bus.pld_avmm2_busy = 1'b0; bus.pld_avmm2_readdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (snap() !== RESET_SNAP) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", snap(), RESET_SNAP);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (snap() !== RESET_SNAP) begin
            miscompares++;
            $display("FAIL reset_idle_hold: got %h expected %h", snap(), RESET_SNAP);
        end
    endtask

    task automatic test_write();
        xfer_t e;
        bus.rq0_write = 1'b1; bus.rq0_reg_addr = 9'h1A5; bus.rq0_writedata = 8'h3C;
        sb_q.push_back('{port: 1'b0, wr: 1'b1, addr: 9'h1A5, data: 8'h3C});
        @(negedge clk);
        vectors++;
        if ({bus.pld_avmm2_request, bus.pld_avmm2_read, bus.pld_avmm2_write,
             bus.rq0_waitrequest, bus.rq1_waitrequest} !== 5'b10011) begin
            miscompares++;
            $display("FAIL write_t1_request: got %b expected 10011", {bus.pld_avmm2_request,
                     bus.pld_avmm2_read, bus.pld_avmm2_write, bus.rq0_waitrequest, bus.rq1_waitrequest});
        end
        @(negedge clk);
        e = sb_q.pop_front();
        vectors++;
        if ({bus.pld_avmm2_request, bus.pld_avmm2_read, bus.pld_avmm2_write,
             bus.pld_avmm2_reg_addr, bus.pld_avmm2_writedata, bus.rq0_waitrequest, bus.rq1_waitrequest}
            !== {1'b1, !e.wr, e.wr, e.addr, e.data, e.port, !e.port}) begin
            miscompares++;
            $display("FAIL write_t2_strobe: got addr %h data %h wr %b rd %b w0 %b w1 %b expected addr %h data %h wr 1",
                     bus.pld_avmm2_reg_addr, bus.pld_avmm2_writedata, bus.pld_avmm2_write,
                     bus.pld_avmm2_read, bus.rq0_waitrequest, bus.rq1_waitrequest, e.addr, e.data);
        end
        bus.rq0_write = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.pld_avmm2_request, bus.pld_avmm2_write, bus.rq0_waitrequest, bus.pld_avmm2_reg_addr}
            !== {1'b0, 1'b0, 1'b1, 9'h1A5}) begin
            miscompares++;
            $display("FAIL write_t3_release: got req %b wr %b w0 %b addr %h expected 0 0 1 1a5",
                     bus.pld_avmm2_request, bus.pld_avmm2_write, bus.rq0_waitrequest, bus.pld_avmm2_reg_addr);
        end
    endtask

    task automatic test_read();
        xfer_t      e;
        logic [9:0] r0_before;
        int         strobe_n = -1;
        int         rdv_n = -1;
        bit         rq0_touched = 1'b0;
        r0_before = {bus.rq0_waitrequest, bus.rq0_readdatavalid, bus.rq0_readdata};
        bus.rq1_read = 1'b1; bus.rq1_reg_addr = 9'h010; bus.pld_avmm2_readdata = 8'hA7;
        sb_q.push_back('{port: 1'b1, wr: 1'b0, addr: 9'h010, data: 8'hA7});
        e = '0;
        for (int n = 1; n <= 30 && rdv_n < 0; n++) begin
            @(negedge clk);
            if ({bus.rq0_waitrequest, bus.rq0_readdatavalid, bus.rq0_readdata} !== r0_before)
                rq0_touched = 1'b1;
            if (bus.pld_avmm2_read && strobe_n < 0) begin
                strobe_n = n;
                e = sb_q.pop_front();
                vectors++;
                if ({bus.pld_avmm2_reg_addr, bus.rq1_waitrequest, bus.pld_avmm2_write} !== {e.addr, 2'b00}) begin
                    miscompares++;
                    $display("FAIL read_strobe: got addr %h w1 %b wr %b expected addr %h w1 0 wr 0",
                             bus.pld_avmm2_reg_addr, bus.rq1_waitrequest, bus.pld_avmm2_write, e.addr);
                end
                bus.rq1_read = 1'b0;
            end
            if (bus.rq1_readdatavalid) begin
                rdv_n = n;
                vectors++;
                if (bus.rq1_readdata !== e.data) begin
                    miscompares++;
                    $display("FAIL read_data: got %h expected %h", bus.rq1_readdata, e.data);
                end
            end
        end
        vectors++;
        if (strobe_n !== 2) begin
            miscompares++;
            $display("FAIL read_strobe_cycle: got %0d expected 2", strobe_n);
        end
        vectors++;
        if (rdv_n - strobe_n !== int'(RD_LAT) + 1) begin
            miscompares++;
            $display("FAIL read_latency: got %0d expected %0d", rdv_n - strobe_n, RD_LAT + 1);
        end
        bus.pld_avmm2_readdata = 8'h00;
        @(negedge clk);
        vectors++;
        if ({bus.rq1_readdatavalid, bus.rq1_readdata} !== {1'b0, 8'hA7}) begin
            miscompares++;
            $display("FAIL read_pulse_hold: got rdv %b data %h expected 0 a7",
                     bus.rq1_readdatavalid, bus.rq1_readdata);
        end
        vectors++;
        if (rq0_touched !== 1'b0) begin
            miscompares++;
            $display("FAIL read_rq0_quiet: got %b expected 0", rq0_touched);
        end
    endtask

    task automatic test_back_to_back();
        xfer_t e;
        int    cnt0 = 0;
        int    cnt1 = 0;
        int    strobes = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.rq0_write = 1'b1; bus.rq0_reg_addr = 9'h040; bus.rq0_writedata = 8'h50;
        bus.rq1_write = 1'b1; bus.rq1_reg_addr = 9'h140; bus.rq1_writedata = 8'hA0;
        sb_q.push_back('{port: 1'b0, wr: 1'b1, addr: 9'h040, data: 8'h50});
        sb_q.push_back('{port: 1'b1, wr: 1'b1, addr: 9'h140, data: 8'hA0});
        for (int n = 0; n < 60 && strobes < 4; n++) begin
            @(negedge clk);
            if (bus.pld_avmm2_write || bus.pld_avmm2_read || !bus.rq0_waitrequest || !bus.rq1_waitrequest) begin
                strobes++;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra_grant: got strobe %0d expected none", strobes);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.pld_avmm2_write, bus.pld_avmm2_read, bus.pld_avmm2_reg_addr, bus.pld_avmm2_writedata,
                         bus.rq0_waitrequest, bus.rq1_waitrequest} !== {2'b10, e.addr, e.data, e.port, !e.port}) begin
                        miscompares++;
                        $display("FAIL b2b_grant_%0d: got addr %h data %h w0 %b w1 %b expected port %0d addr %h data %h",
                                 strobes, bus.pld_avmm2_reg_addr, bus.pld_avmm2_writedata,
                                 bus.rq0_waitrequest, bus.rq1_waitrequest, e.port, e.addr, e.data);
                    end
                end
                if (!bus.rq0_waitrequest) begin
                    cnt0++;
                    if (cnt0 < 2) begin
                        bus.rq0_reg_addr = 9'h041; bus.rq0_writedata = 8'h51;
                        sb_q.push_back('{port: 1'b0, wr: 1'b1, addr: 9'h041, data: 8'h51});
                    end else bus.rq0_write = 1'b0;
                end
                if (!bus.rq1_waitrequest) begin
                    cnt1++;
                    if (cnt1 < 2) begin
                        bus.rq1_reg_addr = 9'h141; bus.rq1_writedata = 8'hA1;
                        sb_q.push_back('{port: 1'b1, wr: 1'b1, addr: 9'h141, data: 8'hA1});
                    end else bus.rq1_write = 1'b0;
                end
            end
        end
        bus.rq0_write = 1'b0; bus.rq1_write = 1'b0;
        vectors++;
        if (strobes !== 4 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d strobes, %0d left expected 4, 0", strobes, sb_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_stall();
        xfer_t e;
        int    strobe_n = -1;
        int    rdv_n = -1;
        bus.rq0_read = 1'b1; bus.rq0_reg_addr = 9'h0F3;
        bus.pld_avmm2_busy = 1'b1; bus.pld_avmm2_readdata = 8'h22;
        sb_q.push_back('{port: 1'b0, wr: 1'b0, addr: 9'h0F3, data: 8'h5E});
        e = '0;
        for (int n = 1; n <= 40 && rdv_n < 0; n++) begin
            @(negedge clk);
            if (bus.pld_avmm2_read && strobe_n < 0) begin
                strobe_n = n;
                e = sb_q.pop_front();
                vectors++;
                if ({bus.pld_avmm2_reg_addr, bus.rq0_waitrequest} !== {e.addr, 1'b0}) begin
                    miscompares++;
                    $display("FAIL stall_strobe: got addr %h w0 %b expected %h 0",
                             bus.pld_avmm2_reg_addr, bus.rq0_waitrequest, e.addr);
                end
                bus.rq0_read = 1'b0;
            end
            if (bus.rq0_readdatavalid) begin
                rdv_n = n;
                vectors++;
                if (bus.rq0_readdata !== e.data) begin
                    miscompares++;
                    $display("FAIL stall_data: got %h expected %h", bus.rq0_readdata, e.data);
                end
            end
            if (strobe_n < 0) begin
                bus.pld_avmm2_busy = (n <= 10);
            end else if (n >= strobe_n + 4 && n <= strobe_n + 6) begin
                bus.pld_avmm2_busy = 1'b1; bus.pld_avmm2_readdata = 8'h11;
            end else begin
                bus.pld_avmm2_busy = 1'b0;
                bus.pld_avmm2_readdata = (n == strobe_n + 7) ? 8'h5E : 8'h22;
            end
        end
        bus.pld_avmm2_busy = 1'b0;
        vectors++;
        if (strobe_n !== 12) begin
            miscompares++;
            $display("FAIL stall_req_delay: got strobe at %0d expected 12", strobe_n);
        end
        vectors++;
        if (rdv_n - strobe_n !== int'(RD_LAT) + 4) begin
            miscompares++;
            $display("FAIL stall_rd_delay: got %0d expected %0d", rdv_n - strobe_n, RD_LAT + 4);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        xfer_t e;
        int    strobe_n = -1;
        int    rdv_n = -1;
        bit    saw_rdv = 1'b0;
        bus.rq1_read = 1'b1; bus.rq1_reg_addr = 9'h077; bus.pld_avmm2_readdata = 8'h99;
        sb_q.push_back('{port: 1'b1, wr: 1'b0, addr: 9'h077, data: 8'h99});
        for (int n = 1; n <= 20 && strobe_n < 0; n++) begin
            @(negedge clk);
            if (bus.pld_avmm2_read) begin
                strobe_n = n;
                bus.rq1_read = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (snap() !== RESET_SNAP) begin
            miscompares++;
            $display("FAIL midreset_state: got %h expected %h", snap(), RESET_SNAP);
        end
        void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.rq1_readdatavalid || bus.rq0_readdatavalid) saw_rdv = 1'b1;
        end
        vectors++;
        if (saw_rdv !== 1'b0 || strobe_n < 0) begin
            miscompares++;
            $display("FAIL midreset_no_rdv: got rdv %b strobe_at %0d expected rdv 0", saw_rdv, strobe_n);
        end
        strobe_n = -1;
        bus.rq1_read = 1'b1; bus.rq1_reg_addr = 9'h078; bus.pld_avmm2_readdata = 8'h3D;
        sb_q.push_back('{port: 1'b1, wr: 1'b0, addr: 9'h078, data: 8'h3D});
        e = '0;
        for (int n = 1; n <= 30 && rdv_n < 0; n++) begin
            @(negedge clk);
            if (bus.pld_avmm2_read && strobe_n < 0) begin
                strobe_n = n;
                e = sb_q.pop_front();
                bus.rq1_read = 1'b0;
            end
            if (bus.rq1_readdatavalid) rdv_n = n;
        end
        vectors++;
        if ({rdv_n - strobe_n, bus.rq1_readdata} !== {int'(RD_LAT) + 1, e.data}) begin
            miscompares++;
            $display("FAIL midreset_next_read: got delay %0d data %h expected %0d %h",
                     rdv_n - strobe_n, bus.rq1_readdata, RD_LAT + 1, e.data);
        end
        @(negedge clk);
    endtask

`ifdef C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN
    task automatic test_timeout();
        xfer_t e;
        int    rdv_n = -1;
        bit    strobe_seen = 1'b0;
        bus.rq0_read = 1'b1; bus.rq0_reg_addr = 9'h0AA; bus.pld_avmm2_busy = 1'b1;
        sb_q.push_back('{port: 1'b0, wr: 1'b0, addr: 9'h0AA, data: 8'hFF});
        for (int n = 1; n <= 40 && rdv_n < 0; n++) begin
            @(negedge clk);
            if (bus.pld_avmm2_read || bus.pld_avmm2_write) strobe_seen = 1'b1;
            if (bus.rq0_readdatavalid) begin
                rdv_n = n;
                e = sb_q.pop_front();
                vectors++;
                if ({bus.rq0_readdata, bus.rq0_waitrequest, arb_timeout, bus.pld_avmm2_request}
                    !== {e.data, 3'b010}) begin
                    miscompares++;
                    $display("FAIL timeout_return: got data %h w0 %b to %b req %b expected %h 0 1 0",
                             bus.rq0_readdata, bus.rq0_waitrequest, arb_timeout,
                             bus.pld_avmm2_request, e.data);
                end
                bus.rq0_read = 1'b0;
            end
        end
        vectors++;
        if (rdv_n !== int'(TMO) + 1 || strobe_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_cycle: got rdv at %0d strobe %b expected %0d 0", rdv_n, strobe_seen, TMO + 1);
        end
        bus.pld_avmm2_busy = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if ({arb_timeout, bus.rq0_readdatavalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_sticky: got to %b rdv %b expected 1 0", arb_timeout, bus.rq0_readdatavalid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_stall();
        test_reset_mid();
`ifdef C3AIBADAPT_AVMM2_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
